sram_loader: RTL and testbench

//  Copies a contiguous image from the on-chip 8-bit boot ROM (Avalon-MM slave, 1-cycle read latency)

---
 rtl/sram_loader_pkg.sv | 18 +
 rtl/sram_loader_if.sv | 32 +++
 rtl/sram_cycle_timer.sv | 33 +++
 rtl/sram_loader.sv | 151 +++++++++++++++
 tb/tb_sram_loader.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_loader_pkg.sv
// Shared types and constants for the boot-ROM to SRAM copy engine.
// No logic; latency/backpressure properties live in the modules that import this.
// Optional verify read-back is enabled by SRAM_LOADER_VERIFY_EN.
package sram_loader_pkg;

    // NEXT is the word-advance decision; it is resolved in the last cycle of each word.
    typedef enum logic [3:0] {
        IDLE, ROM_RD, ROM_WAIT, LATCH, SETUP, WRITE, HOLD, VRD, VCMP, NEXT, FIN
    } state_e;

    localparam int ROM_LAT    = 1;
    localparam int VRD_CYCLES = 2;

    function automatic int cnt_width(input int max_cycles);
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/sram_loader_if.sv
// ROM read port and SRAM pin bundle between the loader (master) and ROM/pads (slave).
// Purely structural, no latency of its own.
// No backpressure: the ROM has fixed latency and the SRAM is asynchronous.
interface sram_loader_if #(
    parameter int ROM_AW  = 8,
    parameter int DW      = 8,
    parameter int SRAM_AW = 18
);
    logic [ROM_AW-1:0]  rom_address;
    logic               rom_chipselect;
    logic               rom_clken;
    logic [DW-1:0]      rom_readdata;
    logic [SRAM_AW-1:0] sram_addr;
    logic [DW-1:0]      sram_dq_out;
    logic               sram_dq_oe;
    logic [DW-1:0]      sram_dq_in;
    logic               sram_ce_n;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport master (
        output rom_address, rom_chipselect, rom_clken,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n,
        input  rom_readdata, sram_dq_in
    );

    modport slave (
        input  rom_address, rom_chipselect, rom_clken,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n,
        output rom_readdata, sram_dq_in
    );
endinterface

// File: rtl/sram_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Loading N-1 gives expiry after N cycles in the following state.
// No backpressure; load always wins over the decrement.
module sram_cycle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);
endmodule

// File: rtl/sram_loader.sv
// Copies LEN bytes from boot ROM to async SRAM; SRAM_LOADER_VERIFY_EN adds per-word read-back.
// Latency: LEN*(WE_CYCLES+5)+1 cycles start->done (+3 cycles/word with verify).
// No backpressure; start while busy is dropped, reset aborts immediately.
module sram_loader
    import sram_loader_pkg::*;
#(
    parameter int ROM_AW    = 8,
    parameter int DW        = 8,
    parameter int SRAM_AW   = 18,
    parameter int SRAM_BASE = 0,
    parameter int LEN       = 256,
    parameter int WE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    sram_loader_if.master bus
);
    localparam int IW       = ROM_AW + 1;
    localparam int MAX_WAIT = (WE_CYCLES > VRD_CYCLES) ? WE_CYCLES : VRD_CYCLES;
    localparam int TW       = cnt_width((MAX_WAIT > ROM_LAT) ? MAX_WAIT : ROM_LAT);

    localparam logic [SRAM_AW-1:0] BASE_A   = SRAM_AW'(SRAM_BASE);
    localparam logic [IW-1:0]      LAST_IDX = IW'(LEN - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_expired;
    logic            word_end;
`ifdef SRAM_LOADER_VERIFY_EN
    logic            err_q, err_d;
`endif

    sram_cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        word_end = 1'b0;
`ifdef SRAM_LOADER_VERIFY_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ROM_RD;
                    idx_d   = '0;
`ifdef SRAM_LOADER_VERIFY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ROM_RD: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(ROM_LAT - 1);
                state_d  = ROM_WAIT;
            end
            ROM_WAIT: if (tmr_expired) state_d = LATCH;
            LATCH: begin
                wdata_d = bus.rom_readdata;
                state_d = SETUP;
            end
            SETUP: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(WE_CYCLES - 1);
                state_d  = WRITE;
            end
            WRITE: if (tmr_expired) state_d = HOLD;
`ifdef SRAM_LOADER_VERIFY_EN
            HOLD: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(VRD_CYCLES - 1);
                state_d  = VRD;
            end
            VRD: if (tmr_expired) state_d = VCMP;
            VCMP: begin
                if (bus.sram_dq_in != wdata_q) err_d = 1'b1;
                word_end = 1'b1;
            end
`else
            HOLD: word_end = 1'b1;
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Word advance (NEXT) costs no cycle of its own.
        if (word_end) begin
            if (idx_q == LAST_IDX) begin
                state_d = FIN;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ROM_RD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wdata_q <= '0;
`ifdef SRAM_LOADER_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
`ifdef SRAM_LOADER_VERIFY_EN
            err_q   <= err_d;
`endif
        end
    end

    // Pins decode straight from registered state, so a reset edge clears them all at once.
    assign busy               = (state_q != IDLE);
    assign done               = (state_q == FIN);
    assign bus.rom_address    = idx_q[ROM_AW-1:0];
    assign bus.rom_chipselect = (state_q == ROM_RD);
    assign bus.rom_clken      = 1'b1;
    assign bus.sram_addr      = BASE_A + SRAM_AW'(idx_q);
    assign bus.sram_dq_out    = wdata_q;
    assign bus.sram_dq_oe     = (state_q == SETUP) || (state_q == WRITE) || (state_q == HOLD);
    assign bus.sram_we_n      = (state_q != WRITE);
`ifdef SRAM_LOADER_VERIFY_EN
    assign bus.sram_ce_n      = !((state_q == SETUP) || (state_q == WRITE) || (state_q == HOLD) ||
                                  (state_q == VRD)   || (state_q == VCMP));
    assign bus.sram_oe_n      = !((state_q == VRD) || (state_q == VCMP));
    assign error              = err_q;
`else
    assign bus.sram_ce_n      = !((state_q == SETUP) || (state_q == WRITE) || (state_q == HOLD));
    assign bus.sram_oe_n      = 1'b1;
    assign error              = 1'b0;
`endif
endmodule

// File: tb/tb_sram_loader.sv
// Directed bench: full 256-byte copy, ignored start, mid-write reset, WE_CYCLES=3 with address wrap,
// and (with SRAM_LOADER_VERIFY_EN) a stuck-bit read-back error.
`timescale 1ns/1ps
module tb_sram_loader;
    import sram_loader_pkg::*;

    localparam int M_LEN  = 256;
    localparam int M_WE   = 2;
    localparam int A_LEN  = 8;
    localparam int A_WE   = 3;
    localparam int A_BASE = (1 << 18) - 4;
`ifdef SRAM_LOADER_VERIFY_EN
    localparam int VX = 3;
`else
    localparam int VX = 0;
`endif
    localparam int M_PER  = M_WE + 5 + VX;       // 7 cycles/word without verify
    localparam int M_DONE = M_LEN * M_PER + 1;   // 1793 without verify
    localparam int A_DONE = A_LEN * (A_WE + 5 + VX) + 1; // 65 without verify

    logic clk = 1'b0;
    logic rst;
    logic m_start, m_busy, m_done, m_error;
    logic a_start, a_busy, a_done, a_error;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   run_id  = 0;
    logic stuck_en = 1'b0;

    always #5 clk = ~clk;

    sram_loader_if #(.ROM_AW(8), .DW(8), .SRAM_AW(18)) m_bus ();
    sram_loader_if #(.ROM_AW(8), .DW(8), .SRAM_AW(18)) a_bus ();

    sram_loader #(.ROM_AW(8), .DW(8), .SRAM_AW(18), .SRAM_BASE(0),
                  .LEN(M_LEN), .WE_CYCLES(M_WE)) u_main (
        .clk(clk), .reset(rst), .start(m_start), .busy(m_busy),
        .done(m_done), .error(m_error), .bus(m_bus.master));

    sram_loader #(.ROM_AW(8), .DW(8), .SRAM_AW(18), .SRAM_BASE(A_BASE),
                  .LEN(A_LEN), .WE_CYCLES(A_WE)) u_alt (
        .clk(clk), .reset(rst), .start(a_start), .busy(a_busy),
        .done(a_done), .error(a_error), .bus(a_bus.master));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ROM models: 1-cycle latency, byte[i] = i ^ 0xA5
    logic [7:0] rom_img [0:255];
    initial for (int i = 0; i < 256; i++) rom_img[i] = 8'(i) ^ 8'hA5;

    always @(posedge clk) begin
        if (m_bus.rom_chipselect && m_bus.rom_clken) m_bus.rom_readdata <= rom_img[m_bus.rom_address];
        if (a_bus.rom_chipselect && a_bus.rom_clken) a_bus.rom_readdata <= rom_img[a_bus.rom_address];
    end

    // Main SRAM model: commit on we_n rising while selected; stamp records which run wrote it.
    logic [7:0] m_mem   [0:255];
    int         m_stamp [0:255];
    logic       m_we_prev = 1'b1;
    int         m_done_cnt = 0;

    always @(negedge clk) begin
        if (m_we_prev === 1'b0 && m_bus.sram_we_n === 1'b1 && m_bus.sram_ce_n === 1'b0) begin
            m_mem[m_bus.sram_addr[7:0]]   = m_bus.sram_dq_out;
            m_stamp[m_bus.sram_addr[7:0]] = run_id;
        end
        m_we_prev = m_bus.sram_we_n;
        if (m_done === 1'b1) m_done_cnt++;
    end

    always_comb begin
        m_bus.sram_dq_in = 8'h00;
        if (m_bus.sram_ce_n === 1'b0 && m_bus.sram_oe_n === 1'b0) begin
            m_bus.sram_dq_in = m_mem[m_bus.sram_addr[7:0]];
            if (stuck_en && m_bus.sram_addr == 18'h21) m_bus.sram_dq_in[0] = 1'b1;
        end
    end

    assign a_bus.sram_dq_in = 8'h00;

    // Alt monitor: write log, we_n pulse width, addr/dq stable around each pulse.
    logic [17:0] a_log_addr [0:15];
    logic [7:0]  a_log_dat  [0:15];
    int          a_nwr = 0;
    int          a_low = 0;
    logic        a_we_prev = 1'b1;
    logic [17:0] a_prev_addr;
    logic [7:0]  a_prev_dq;
    logic        a_prev_oe;

    always @(negedge clk) begin
        if (a_bus.sram_we_n === 1'b0) begin
            if (a_we_prev === 1'b1) begin
                chk("we3_setup_addr", a_bus.sram_addr, a_prev_addr);
                chk("we3_setup_dq", a_bus.sram_dq_out, a_prev_dq);
                chk("we3_setup_oe", a_prev_oe, 1);
                a_low = 0;
            end
            a_low++;
        end else if (a_we_prev === 1'b0) begin
            chk("we3_width", a_low, A_WE);
            chk("we3_hold_addr", a_bus.sram_addr, a_prev_addr);
            chk("we3_hold_dq", a_bus.sram_dq_out, a_prev_dq);
            chk("we3_hold_oe", a_bus.sram_dq_oe, 1);
            if (a_nwr < 16) begin
                a_log_addr[a_nwr] = a_bus.sram_addr;
                a_log_dat[a_nwr]  = a_bus.sram_dq_out;
            end
            a_nwr++;
        end
        a_we_prev   = a_bus.sram_we_n;
        a_prev_addr = a_bus.sram_addr;
        a_prev_dq   = a_bus.sram_dq_out;
        a_prev_oe   = a_bus.sram_dq_oe;
    end

    // All stimulus tasks leave time at #1 after a rising edge.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_main();
        m_start = 1'b1;
        adv(1);
        m_start = 1'b0;
    endtask

    task automatic wait_main(input int cyc0, output int cyc);
        cyc = cyc0;
        while (m_done !== 1'b1 && cyc < 8000) begin
            adv(1);
            cyc++;
        end
    endtask

    task automatic check_image(input string tag, input int id);
        int bad = 0;
        for (int i = 0; i < 256; i++)
            if (m_mem[i] !== (8'(i) ^ 8'hA5) || m_stamp[i] != id) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        int cyc;
        int d0;
        for (int i = 0; i < 256; i++) m_stamp[i] = 0;
        rst = 1'b1; m_start = 1'b0; a_start = 1'b0;
        adv(3);

        // Reset values
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_error", m_error, 0);
        chk("rst_rom_addr", m_bus.rom_address, 0);
        chk("rst_rom_cs", m_bus.rom_chipselect, 0);
        chk("rst_rom_clken", m_bus.rom_clken, 1);
        chk("rst_sram_addr", m_bus.sram_addr, 0);
        chk("rst_dq_out", m_bus.sram_dq_out, 0);
        chk("rst_dq_oe", m_bus.sram_dq_oe, 0);
        chk("rst_ce_n", m_bus.sram_ce_n, 1);
        chk("rst_we_n", m_bus.sram_we_n, 1);
        chk("rst_oe_n", m_bus.sram_oe_n, 1);
        chk("rst_alt_addr", a_bus.sram_addr, A_BASE);

        // Start coincident with reset is dropped
        m_start = 1'b1;
        adv(1);
        m_start = 1'b0;
        chk("start_in_reset", m_busy, 0);
        rst = 1'b0;
        adv(1);

        // Run 1: plain copy
        run_id = 1;
        d0 = m_done_cnt;
        pulse_main();
        chk("m_busy_run", m_busy, 1);
        chk("m_first_cs", m_bus.rom_chipselect, 1);
        wait_main(1, cyc);
        chk("m_done_cycle", cyc, M_DONE);
        adv(1);
        chk("m_done_pulse", m_done, 0);
        chk("m_busy_after", m_busy, 0);
        chk("m_done_count", m_done_cnt - d0, 1);
        chk("m_error_run1", m_error, 0);
        check_image("m_image_run1", 1);

        // Run 2: start re-pulsed during word 10 is ignored
        run_id = 2;
        d0 = m_done_cnt;
        pulse_main();
        adv(10 * M_PER + 2);
        chk("m_rom_addr_w10", m_bus.rom_address, 10);
        m_start = 1'b1;
        adv(1);
        m_start = 1'b0;
        wait_main(10 * M_PER + 4, cyc);
        chk("m_done_cycle_ign", cyc, M_DONE);
        adv(1);
        chk("m_done_count_ign", m_done_cnt - d0, 1);
        check_image("m_image_run2", 2);

        // Run 3: reset in WRITE of word 100, then a clean restart
        run_id = 3;
        pulse_main();
        adv(100 * M_PER + 4);
        chk("m_in_write", m_bus.sram_we_n, 0);
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        chk("abort_we_n", m_bus.sram_we_n, 1);
        chk("abort_ce_n", m_bus.sram_ce_n, 1);
        chk("abort_dq_oe", m_bus.sram_dq_oe, 0);
        chk("abort_busy", m_busy, 0);
        chk("abort_addr", m_bus.sram_addr, 0);
        adv(1);
        run_id = 4;
        pulse_main();
        wait_main(1, cyc);
        chk("m_done_cycle_rst", cyc, M_DONE);
        adv(1);
        check_image("m_image_run4", 4);

`ifdef SRAM_LOADER_VERIFY_EN
        // Stuck bit0 at 0x21 (byte 0x84); 0x20 holds 0x85 so its read-back still matches
        run_id = 5;
        stuck_en = 1'b1;
        pulse_main();
        adv(34 * M_PER - 1);
        chk("v_error_before", m_error, 0);
        adv(1);
        chk("v_error_after", m_error, 1);
        wait_main(34 * M_PER + 1, cyc);
        chk("v_done_cycle", cyc, M_DONE);
        adv(1);
        chk("v_error_sticky", m_error, 1);
        check_image("v_image", 5);
        stuck_en = 1'b0;
        run_id = 6;
        pulse_main();
        chk("v_error_cleared", m_error, 0);
        wait_main(1, cyc);
        adv(1);
        chk("v_error_clean", m_error, 0);
`endif

        // Alt: WE_CYCLES=3, base 2^18-4, LEN=8 -> addresses wrap to 0..3
        a_start = 1'b1;
        adv(1);
        a_start = 1'b0;
        cyc = 1;
        while (a_done !== 1'b1 && cyc < 1000) begin
            adv(1);
            cyc++;
        end
        chk("a_done_cycle", cyc, A_DONE);
        adv(1);
        chk("a_busy_after", a_busy, 0);
        chk("a_error", a_error, 0);
        chk("a_nwr", a_nwr, A_LEN);
        for (int k = 0; k < A_LEN; k++) begin
            chk("a_wr_addr", a_log_addr[k], (A_BASE + k) % (1 << 18));
            chk("a_wr_dat", a_log_dat[k], 32'(8'(k) ^ 8'hA5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
